// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_t   : controller states (IDLE, RUN)
//   DEF_WIDTH : default operand width
//   CNT_W     : bit-counter width for the default operand width
//   cnt_width : counter width for an arbitrary operand width
package serial_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  // Operand width is at least 2, so this never evaluates below 1.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus of the serial subtractor.
//   master : control side, drives start/a/b and observes the result
//   slave  : subtractor side
// Signals: start, a, b (request/operands); busy, done, diff, borrow, ovf (status/result).
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow, ovf
  );

endinterface

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  // Borrow when y exceeds x, or when the bits are equal and a borrow comes in.
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b, one bit per clock, LSB first.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of serial_subtractor_if (start/a/b in; busy/done/diff/borrow/ovf out)
// An accepted start spends exactly WIDTH cycles in RUN; done pulses for one
// cycle and diff/borrow/ovf hold until the next completion.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sr;
  logic             bff;
  logic [CW-1:0]    cnt;
  logic             a_sign, b_sign;
  logic             d_bit, bo_bit;
  logic             accept, last;

  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             ovf_q;

  full_subtractor_cell u_cell (
    .x    (sa[0]),
    .y    (sb[0]),
    .bin  (bff),
    .d    (d_bit),
    .bout (bo_bit)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(WIDTH - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      bff      <= 1'b0;
      cnt      <= '0;
      a_sign   <= 1'b0;
      b_sign   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      done_q <= last;
      if (accept) begin
        sa     <= bus.a;
        sb     <= bus.b;
        a_sign <= bus.a[WIDTH-1];
        b_sign <= bus.b[WIDTH-1];
        bff    <= 1'b0;
        cnt    <= '0;
      end else if (state == RUN) begin
        sa  <= sa >> 1;
        sb  <= sb >> 1;
        sr  <= {d_bit, sr[WIDTH-1:1]};
        bff <= bo_bit;
        cnt <= cnt + CW'(1);
        if (last) begin
          // Result register takes the shifted value including this bit.
          diff_q   <= {d_bit, sr[WIDTH-1:1]};
          borrow_q <= bo_bit;
          // Overflow: operand signs differ and the result sign disagrees with a.
          ovf_q    <= (a_sign != b_sign) && (d_bit != a_sign);
        end
      end
    end
  end

  assign bus.busy   = (state == RUN);
  assign bus.done   = done_q;
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): directed cases,
// ignored/back-to-back starts, mid-operation reset and random operands
// compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed interpretations.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] d, output logic bo, output logic ov);
    int ai, bi, as_i, bs_i, r;
    ai   = int'(a);
    bi   = int'(b);
    as_i = (ai >= 128) ? ai - 256 : ai;
    bs_i = (bi >= 128) ? bi - 256 : bi;
    r    = as_i - bs_i;
    d    = W'((ai - bi + 256) % 256);
    bo   = (ai < bi);
    ov   = (r > 127) || (r < -128);
  endtask

  // Issue one start, wait for done, compare latency, busy length and result.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    logic [W-1:0] ed;
    logic         eb, eo;
    int           n, busy_cnt;
    model(a, b, ed, eb, eo);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    n = 0;
    busy_cnt = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 8);
    check({tag, " busy_len"}, busy_cnt, 8);
    check({tag, " diff"}, bus.diff, ed);
    check({tag, " borrow"}, bus.borrow, eb);
    check({tag, " ovf"}, bus.ovf, eo);
    @(negedge clk);
    check({tag, " done_pulse"}, bus.done, 0);
  endtask

  initial begin
    int n, done_seen;
    logic [W-1:0] ra, rb;
    n_checks  = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    #23;
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst diff", bus.diff, 0);
    check("rst borrow", bus.borrow, 0);
    check("rst ovf", bus.ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h25, 8'h13, "op25_13");
    do_op(8'h00, 8'h01, "op00_01");
    do_op(8'h80, 8'h01, "op80_01");
    do_op(8'h7F, 8'hFF, "op7f_ff");

    // Ignored start mid-flight, then back-to-back start on the done cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h05;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.done && n < 20) begin
      if (n == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'hAA;
        bus.b     = 8'h55;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    check("ign latency", n, 8);
    check("ign diff", bus.diff, 8'h0B);
    bus.start = 1'b1;
    bus.a     = 8'h05;
    bus.b     = 8'h05;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b busy", bus.busy, 1);
    check("b2b done_clr", bus.done, 0);
    check("b2b diff_hold", bus.diff, 8'h0B);
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
      if (!bus.done && n < 8) check("b2b hold", bus.diff, 8'h0B);
    end
    check("b2b latency", n, 8);
    check("b2b diff", bus.diff, 0);
    check("b2b borrow", bus.borrow, 0);
    check("b2b ovf", bus.ovf, 0);

    // Leave a nonzero result so the reset clear is visible.
    do_op(8'h00, 8'h01, "pre_rst");

    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst busy", bus.busy, 0);
    check("arst done", bus.done, 0);
    check("arst diff", bus.diff, 0);
    check("arst borrow", bus.borrow, 0);
    check("arst ovf", bus.ovf, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("arst no_done", done_seen, 0);
    do_op(8'h9C, 8'h3A, "post_rst");

    for (int i = 0; i < 30; i++) begin
      ra = 8'($urandom);
      rb = (i % 7 == 0) ? ra : 8'($urandom);
      do_op(ra, rb, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got %0d checks", n_checks);
    $fatal(1, "timeout");
  end

endmodule
